// File: rtl/spi_slave_shift.sv
// SPI responder datapath: oversamples sclk/ss_n/mosi in pclk, shifts a TX byte out on miso, assembles the RX byte.
// Latency: pin edge to internal action is SYNC_STAGES+1 pclk; a received byte reaches rx_data one pclk after its 8th sample.
// Backpressure: none toward the master. A full RX register is overwritten (sticky overrun). An empty TX buffer sends IDLE_TX (tx_underrun pulse).
//
// Ports:
//   pclk, preset_n          system clock, asynchronous active-low reset
//   cpol, cpha, lsbfe       SPI mode, captured when ss_n falls
//   sclk_in, ss_n_in, mosi_in  asynchronous pins from the master
//   tx_data, tx_wr, tx_ready   one-entry TX buffer write side
//   rx_rd, rx_data, rx_full, overrun  one-entry RX holding register
//   tx_underrun             one-pclk pulse when IDLE_TX is loaded
//   miso, miso_oe, busy     serial output, its enable, frame-active flag
module spi_slave_shift #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_TX     = 8'hFF
) (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       lsbfe,
  input  logic       sclk_in,
  input  logic       ss_n_in,
  input  logic       mosi_in,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_ready,
  input  logic       rx_rd,
  output logic [7:0] rx_data,
  output logic       rx_full,
  output logic       overrun,
  output logic       tx_underrun,
  output logic       miso,
  output logic       miso_oe,
  output logic       busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  // Synchronizers and edge-detect history
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   ss_d;
  logic                   sclk_s;
  logic                   ss_s;
  logic                   mosi_s;

  // Frame mode, frozen for the duration of a frame
  logic cpol_q;
  logic cpha_q;
  logic lsbfe_q;

  state_t     state_q;
  state_t     state_n;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;
  logic [7:0] tx_buf;
  logic       tx_full;
  logic       byte_done;

  logic       ss_fall;
  logic       ss_rise;
  logic       lead_e;
  logic       trail_e;
  logic       sample_e;
  logic       shift_e;
  logic       abort;
  logic       load_now;
  logic       do_sample;
  logic       do_drive;
  logic [7:0] load_byte;

  // Bit i of the byte in transmit order.
  function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] i, input logic lsb);
    return lsb ? b[i] : b[3'd7 - i];
  endfunction

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      sclk_sync <= {SYNC_STAGES{cpol}};
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= cpol;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign ss_fall  = ss_d & ~ss_s;
  assign ss_rise  = ~ss_d & ss_s;
  // Leading edge moves sclk away from its idle level, trailing edge returns it.
  assign lead_e   = (sclk_s ^ sclk_d) & (sclk_s ^ cpol_q);
  assign trail_e  = (sclk_s ^ sclk_d) & ~(sclk_s ^ cpol_q);
  assign sample_e = cpha_q ? trail_e : lead_e;
  assign shift_e  = cpha_q ? lead_e : trail_e;

  assign busy     = ~ss_s;
  assign tx_ready = ~tx_full;

  // An empty buffer with a write in the same cycle hands tx_data straight to the shifter.
  assign load_byte = tx_full ? tx_buf : (tx_wr ? tx_data : IDLE_TX);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    abort     = 1'b0;
    load_now  = 1'b0;
    do_sample = 1'b0;
    do_drive  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        if (ss_rise) begin
          state_n = ST_IDLE;
          abort   = 1'b1;
        end else begin
          state_n  = ST_SHIFT;
          load_now = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_n = ST_IDLE;
          abort   = 1'b1;
        end else begin
          load_now  = byte_done;
          do_sample = sample_e;
          // With cpha=0 the shift edge right after the 8th sample (bit_cnt wrapped
          // to 0) must not disturb the first bit already placed by the reload.
          do_drive  = shift_e && !byte_done && (cpha_q || bit_cnt != 3'd0);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsbfe_q <= 1'b0;
    end else if (state_q == ST_IDLE && ss_fall) begin
      cpol_q  <= cpol;
      cpha_q  <= cpha;
      lsbfe_q <= lsbfe;
    end
  end

  // Transmit side: TX buffer, shifter and miso.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      tx_buf      <= 8'h00;
      tx_full     <= 1'b0;
      tx_sr       <= 8'h00;
      tx_underrun <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;

      if (load_now) begin
        tx_sr   <= load_byte;
        miso_oe <= 1'b1;
        // cpha=1 waits for the first leading edge before driving bit 0.
        if (!cpha_q) miso <= pick_bit(load_byte, 3'd0, lsbfe_q);
      end else if (do_drive) begin
        miso <= pick_bit(tx_sr, bit_cnt, lsbfe_q);
      end

      if (abort) begin
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end

      if (load_now && tx_full) begin
        tx_full <= 1'b0;
      end else if (load_now && !tx_wr) begin
        tx_underrun <= 1'b1;
      end else if (!load_now && tx_wr && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end
    end
  end

  // Receive side: shifter, bit counter and holding register.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rx_sr     <= 8'h00;
      bit_cnt   <= 3'd0;
      byte_done <= 1'b0;
      rx_data   <= 8'h00;
      rx_full   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      byte_done <= 1'b0;

      if (do_sample) begin
        rx_sr     <= lsbfe_q ? {mosi_s, rx_sr[7:1]} : {rx_sr[6:0], mosi_s};
        bit_cnt   <= bit_cnt + 3'd1;
        byte_done <= (bit_cnt == 3'd7);
      end

      if (abort) bit_cnt <= 3'd0;

      // A completed byte is delivered even if ss_n rises in the same cycle.
      if (byte_done) begin
        rx_data <= rx_sr;
        rx_full <= 1'b1;
        overrun <= rx_rd ? 1'b0 : (overrun | rx_full);
      end else if (rx_rd) begin
        rx_full <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_shift.sv
// Directed-plus-random bench for spi_slave_shift with a behavioural SPI master and reference model.
module tb_spi_slave_shift;

  localparam int HP = 8;  // sclk half period in pclk cycles

  logic       pclk     = 1'b0;
  logic       preset_n = 1'b0;
  logic       cpol     = 1'b0;
  logic       cpha     = 1'b0;
  logic       lsbfe    = 1'b0;
  logic       sclk_in  = 1'b0;
  logic       ss_n_in  = 1'b1;
  logic       mosi_in  = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_wr    = 1'b0;
  logic       rx_rd    = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_full;
  logic       overrun;
  logic       tx_underrun;
  logic       miso;
  logic       miso_oe;
  logic       busy;

  spi_slave_shift #(.SYNC_STAGES(2), .IDLE_TX(8'hFF)) dut (
    .pclk(pclk), .preset_n(preset_n), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
    .sclk_in(sclk_in), .ss_n_in(ss_n_in), .mosi_in(mosi_in),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_ready(tx_ready),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_full(rx_full), .overrun(overrun),
    .tx_underrun(tx_underrun), .miso(miso), .miso_oe(miso_oe), .busy(busy)
  );

  always #5 pclk = ~pclk;

  int checks       = 0;
  int failures     = 0;
  int underrun_cnt = 0;

  always @(posedge pclk) if (tx_underrun === 1'b1) underrun_cnt++;

  // Reference model: bytes written into the TX buffer, and the RX register state.
  logic [7:0] txq[$];
  logic [7:0] m_rx_data  = 8'h00;
  logic       m_rx_full  = 1'b0;
  logic       m_overrun  = 1'b0;
  int         m_underruns = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Every byte load takes the buffered byte, or IDLE_TX when nothing is buffered.
  task automatic model_load(output logic [7:0] exp);
    if (txq.size() > 0) exp = txq.pop_front();
    else begin
      exp = 8'hFF;
      m_underruns++;
    end
  endtask

  task automatic model_rx(input logic [7:0] b);
    if (m_rx_full) m_overrun = 1'b1;
    m_rx_full = 1'b1;
    m_rx_data = b;
  endtask

  task automatic write_tx(input logic [7:0] d);
    check("tx_ready_before_wr", tx_ready, 1);
    tx_data = d;
    tx_wr   = 1'b1;
    wait_cyc(1);
    tx_wr   = 1'b0;
    txq.push_back(d);
    check("tx_ready_after_wr", tx_ready, 0);
  endtask

  task automatic read_rx();
    rx_rd = 1'b1;
    wait_cyc(1);
    rx_rd = 1'b0;
    m_rx_full = 1'b0;
    m_overrun = 1'b0;
    wait_cyc(1);
    check("rx_rd_clears", {rx_full, overrun}, 0);
  endtask

  task automatic frame_start(input logic p, input logic h, input logic l);
    cpol = p; cpha = h; lsbfe = l;
    sclk_in = p;
    wait_cyc(4);
    ss_n_in = 1'b0;
    wait_cyc(HP);
    check("busy_in_frame", busy, 1);
    check("miso_oe_in_frame", miso_oe, 1);
  endtask

  // Behavioural master: drives mosi, toggles sclk, samples miso on the sample edge.
  task automatic xfer_bits(input logic [15:0] mtx, input int nbits, output logic [15:0] mrx);
    int pos;
    int k;
    mrx = '0;
    for (int i = 0; i < nbits; i++) begin
      pos = i % 8;
      k   = (i / 8) * 8 + (lsbfe ? pos : 7 - pos);
      if (!cpha) begin
        mosi_in = mtx[k];
        wait_cyc(HP);
        mrx[k]  = miso;
        sclk_in = ~cpol;
        wait_cyc(HP);
        sclk_in = cpol;
      end else begin
        wait_cyc(HP);
        sclk_in = ~cpol;
        mosi_in = mtx[k];
        wait_cyc(HP);
        mrx[k]  = miso;
        sclk_in = cpol;
      end
    end
  endtask

  // ss_n is released one pclk after the last sclk edge.
  task automatic frame_end();
    wait_cyc(1);
    ss_n_in = 1'b1;
    mosi_in = 1'b0;
    wait_cyc(8);
    check("miso_oe_after_frame", miso_oe, 0);
    check("busy_after_frame", busy, 0);
  endtask

  // A full frame of nbytes. Every completed byte reloads the shifter while ss_n is low.
  // With cpha=0 the last sample precedes the final trailing edge, so that extra reload
  // always happens before the release; with cpha=1 the prompt release cancels it.
  task automatic run_frame(input logic p, input logic h, input logic l, input int nbytes,
                           input logic [15:0] mtx, input string tag);
    logic [15:0] mrx;
    logic [7:0]  exp;
    frame_start(p, h, l);
    xfer_bits(mtx, nbytes * 8, mrx);
    frame_end();
    for (int b = 0; b < nbytes; b++) begin
      model_load(exp);
      check({tag, "_master_rx"}, mrx[b*8 +: 8], exp);
      model_rx(mtx[b*8 +: 8]);
    end
    if (!h) model_load(exp);
    check({tag, "_rx_data"}, rx_data, m_rx_data);
    check({tag, "_rx_full"}, rx_full, m_rx_full);
    check({tag, "_overrun"}, overrun, m_overrun);
    check({tag, "_underruns"}, underrun_cnt, m_underruns);
  endtask

  initial begin
    logic [15:0] mrx;
    logic [15:0] mtx;
    logic [7:0]  exp;
    logic [7:0]  b;
    logic [1:0]  mode;
    int          u0;
    int          nb;

    // Reset state
    wait_cyc(2);
    check("reset_outputs", {rx_data, miso, miso_oe, rx_full, overrun, tx_ready, busy, tx_underrun},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    preset_n = 1'b1;
    wait_cyc(4);
    check("idle_outputs", {miso_oe, rx_full, tx_ready, busy}, 4'b0010);

    // 1: mode 0, MSB first
    write_tx(8'hA5);
    run_frame(1'b0, 1'b0, 1'b0, 1, 16'h003C, "t1");
    check("t1_rx_byte", rx_data, 8'h3C);
    read_rx();

    // 2: all four modes, LSB first
    for (int m = 0; m < 4; m++) begin
      mode = m[1:0];
      write_tx(8'h81);
      run_frame(mode[1], mode[0], 1'b1, 1, 16'h0001, "t2");
      check("t2_rx_byte", rx_data, 8'h01);
      read_rx();
    end

    // 3 + 4: two back-to-back bytes, only the first written, no rx_rd in between
    b = 8'($urandom);
    write_tx(b);
    u0 = underrun_cnt;
    mtx = 16'($urandom);
    run_frame(1'b1, 1'b1, 1'b0, 2, mtx, "t3");
    check("t3_underrun_pulses", underrun_cnt - u0, 1);
    check("t4_overrun_set", overrun, 1);
    check("t4_rx_second", rx_data, mtx[15:8]);
    read_rx();

    // 5: ss_n released after 5 bits
    b = 8'($urandom);
    write_tx(b);
    frame_start(1'b0, 1'b0, 1'b0);
    xfer_bits(16'($urandom), 5, mrx);
    frame_end();
    model_load(exp);
    check("t5_partial_bits", mrx[7:3], exp[7:3]);
    check("t5_rx_full", rx_full, 0);
    write_tx(8'hC6);
    run_frame(1'b0, 1'b0, 1'b0, 1, 16'h0093, "t5_next");

    // 6: reset mid-byte with an unread byte pending
    write_tx(8'h33);
    frame_start(1'b0, 1'b0, 1'b0);
    xfer_bits(16'h00C3, 4, mrx);
    preset_n = 1'b0;
    #1;
    check("t6_reset_outputs", {rx_data, miso, miso_oe, rx_full, overrun, tx_ready, busy, tx_underrun},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    ss_n_in = 1'b1;
    wait_cyc(3);
    preset_n = 1'b1;
    txq.delete();
    m_rx_full = 1'b0;
    m_overrun = 1'b0;
    m_rx_data = 8'h00;
    wait_cyc(3);
    write_tx(8'h5A);
    run_frame(1'b0, 1'b0, 1'b0, 1, 16'h005A, "t6_after");
    check("t6_rx_byte", rx_data, 8'h5A);
    read_rx();

    // Random frames against the model
    for (int i = 0; i < 10; i++) begin
      mode = 2'($urandom);
      nb   = $urandom_range(1, 2);
      if ($urandom_range(0, 1) == 1) write_tx(8'($urandom));
      mtx = 16'($urandom);
      run_frame(mode[1], mode[0], 1'($urandom), nb, mtx, "rand");
      if ($urandom_range(0, 1) == 1) read_rx();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
